// File: rtl/grid_pkg.sv
// Shared constants for the grid explorer: cell codes, command codes, FSM states.
package grid_pkg;

    localparam logic [2:0] CELL_UNKNOWN  = 3'd0;
    localparam logic [2:0] CELL_CURRENT  = 3'd1;
    localparam logic [2:0] CELL_ENTRANCE = 3'd2;
    localparam logic [2:0] CELL_EXIT     = 3'd3;
    localparam logic [2:0] CELL_BLANK    = 3'd4;
    localparam logic [2:0] CELL_WALL     = 3'd5;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_RIGHT = 3'd1;
    localparam logic [2:0] CMD_LEFT  = 3'd2;
    localparam logic [2:0] CMD_UP    = 3'd3;
    localparam logic [2:0] CMD_DOWN  = 3'd4;
    localparam logic [2:0] CMD_QUIT  = 3'd5;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CHECK  = 2'd1;
    localparam state_t ST_REVEAL = 2'd2;
    localparam state_t ST_HALT   = 2'd3;

endpackage

// File: rtl/grid_explorer_if.sv
// Command handshake and map-load bus between a controller and grid_explorer.
interface grid_explorer_if #(
    parameter int IDX_W = 7
);
    logic             cmd_valid;
    logic [2:0]       cmd;
    logic             cmd_ready;
    logic             map_we;
    logic [IDX_W-1:0] map_waddr;
    logic [2:0]       map_wdata;

    modport master (
        output cmd_valid, cmd, map_we, map_waddr, map_wdata,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd, map_we, map_waddr, map_wdata,
        output cmd_ready
    );
endinterface

// File: rtl/reveal_scanner.sv
// Walks the (2R+1)x(2R+1) window around a centre cell, one cell per cycle,
// flagging cells that are on-map and inside the Manhattan diamond.
module reveal_scanner #(
    parameter int MAP_W    = 10,
    parameter int MAP_H    = 10,
    parameter int REVEAL_R = 2,
    parameter int IDX_W    = $clog2(MAP_W*MAP_H),
    parameter int XW       = $clog2(MAP_W),
    parameter int YW       = $clog2(MAP_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [XW-1:0]    i_cx,
    input  logic [YW-1:0]    i_cy,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_we,
    output logic             o_last
);
    localparam logic signed [3:0] R_POS = 4'(REVEAL_R);
    localparam logic signed [3:0] R_NEG = -R_POS;

    logic signed [3:0] r_dx;
    logic signed [3:0] r_dy;
    logic              r_busy;
    int                w_tx;
    int                w_ty;
    int                w_dist;
    logic              w_in_map;

    // Offset counters; reset leaves the scanner armed so the entrance window is revealed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dx   <= R_NEG;
            r_dy   <= R_NEG;
            r_busy <= 1'b1;
        end else if (i_start) begin
            r_dx   <= R_NEG;
            r_dy   <= R_NEG;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_dx == R_POS) begin
                r_dx <= R_NEG;
                if (r_dy == R_POS) r_busy <= 1'b0;
                else               r_dy   <= r_dy + 4'sd1;
            end else begin
                r_dx <= r_dx + 4'sd1;
            end
        end
    end

    // Bounds and diamond test on the current window cell.
    always_comb begin
        w_tx     = int'(i_cx) + int'(r_dx);
        w_ty     = int'(i_cy) + int'(r_dy);
        w_dist   = ((r_dx < 0) ? -int'(r_dx) : int'(r_dx)) +
                   ((r_dy < 0) ? -int'(r_dy) : int'(r_dy));
        w_in_map = (w_tx >= 0) && (w_tx < MAP_W) && (w_ty >= 0) && (w_ty < MAP_H);
        o_we     = r_busy && w_in_map && (w_dist <= REVEAL_R);
        o_idx    = IDX_W'(w_ty * MAP_W + w_tx);
        o_last   = r_busy && (r_dx == R_POS) && (r_dy == R_POS);
    end

endmodule

// File: rtl/grid_explorer.sv
// Grid map engine: cell map, player position, fog-of-war and move sequencing.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// CHECK  | one cycle: evaluate target cell, move or bump
// REVEAL | scanner sweeps the window around pos
// HALT   | exit reached or quit; only reset leaves
module grid_explorer
    import grid_pkg::*;
#(
    parameter int MAP_W        = 10,
    parameter int MAP_H        = 10,
    parameter int REVEAL_R     = 2,
    parameter int ENTRANCE_IDX = 50,
    parameter int EXIT_IDX     = 59,
    parameter int IDX_W        = $clog2(MAP_W*MAP_H)
) (
    input  logic             clk,
    input  logic             reset,
    grid_explorer_if.slave   bus,
    input  logic [IDX_W-1:0] i_rd_addr,
    output logic [2:0]       o_rd_data,
    output logic [IDX_W-1:0] o_pos,
    output logic             o_bump,
    output logic             o_done,
    output logic [15:0]      o_move_count
);
    localparam int N  = MAP_W * MAP_H;
    localparam int XW = $clog2(MAP_W);
    localparam int YW = $clog2(MAP_H);
    localparam logic [XW-1:0]    ENT_X  = XW'(ENTRANCE_IDX % MAP_W);
    localparam logic [YW-1:0]    ENT_Y  = YW'(ENTRANCE_IDX / MAP_W);
    localparam logic [IDX_W-1:0] ENT_A  = IDX_W'(ENTRANCE_IDX);
    localparam logic [IDX_W-1:0] EXIT_A = IDX_W'(EXIT_IDX);

    state_t           r_state;
    logic [2:0]       r_cmd;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [2:0]       r_map [N];
    logic [N-1:0]     r_seen;
    logic             r_bump;
    logic             r_done;
    logic [15:0]      r_count;

    logic [IDX_W-1:0] w_pos;
    logic [XW-1:0]    w_tx;
    logic [YW-1:0]    w_ty;
    logic             w_off;
    logic [IDX_W-1:0] w_tidx;
    logic             w_blocked;
    logic             w_start;
    logic             w_wr_ok;
    logic [IDX_W-1:0] w_sc_idx;
    logic             w_sc_we;
    logic             w_sc_last;

    assign w_pos         = IDX_W'(int'(r_y) * MAP_W + int'(r_x));
    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign o_pos         = w_pos;
    assign o_bump        = r_bump;
    assign o_done        = r_done;
    assign o_move_count  = r_count;
    assign w_start       = (r_state == ST_CHECK) && !w_blocked;

    // Target cell of the latched move using true x/y bounds.
    always_comb begin
        w_tx  = r_x;
        w_ty  = r_y;
        w_off = 1'b0;
        case (r_cmd)
            CMD_RIGHT: if (int'(r_x) == MAP_W-1) w_off = 1'b1; else w_tx = r_x + XW'(1);
            CMD_LEFT:  if (r_x == '0)            w_off = 1'b1; else w_tx = r_x - XW'(1);
            CMD_UP:    if (r_y == '0)            w_off = 1'b1; else w_ty = r_y - YW'(1);
            CMD_DOWN:  if (int'(r_y) == MAP_H-1) w_off = 1'b1; else w_ty = r_y + YW'(1);
            default:   w_off = 1'b1;
        endcase
        w_tidx    = IDX_W'(int'(w_ty) * MAP_W + int'(w_tx));
        w_blocked = w_off || (r_map[w_tidx] == CELL_WALL);
    end

    // Map-load filter: fixed cells, walls under the player and off-map writes are dropped.
    assign w_wr_ok = bus.map_we && (int'(bus.map_waddr) < N) &&
                     (bus.map_waddr != ENT_A) && (bus.map_waddr != EXIT_A) &&
                     !((bus.map_wdata == CELL_WALL) && (bus.map_waddr == w_pos));

    // Display read port.
    always_comb begin
        if (i_rd_addr == w_pos)         o_rd_data = CELL_CURRENT;
        else if (int'(i_rd_addr) >= N)  o_rd_data = CELL_UNKNOWN;
        else if (!r_seen[i_rd_addr])    o_rd_data = CELL_UNKNOWN;
        else                            o_rd_data = r_map[i_rd_addr];
    end

    reveal_scanner #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .REVEAL_R(REVEAL_R), .IDX_W(IDX_W)
    ) u_scan (
        .clk    (clk),
        .rst    (reset),
        .i_start(w_start),
        .i_cx   (r_x),
        .i_cy   (r_y),
        .o_idx  (w_sc_idx),
        .o_we   (w_sc_we),
        .o_last (w_sc_last)
    );

    // Cell map storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                r_map[i] <= (i == ENTRANCE_IDX) ? CELL_ENTRANCE :
                            (i == EXIT_IDX)     ? CELL_EXIT     : CELL_BLANK;
        end else if (w_wr_ok) begin
            r_map[bus.map_waddr] <= bus.map_wdata;
        end
    end

    // Fog-of-war bitmap, filled by the scanner during REVEAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   r_seen <= '0;
        else if (r_state == ST_REVEAL && w_sc_we)    r_seen[w_sc_idx] <= 1'b1;
    end

    // Control FSM with position, bump, done and move counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_REVEAL;
            r_cmd   <= CMD_NOP;
            r_x     <= ENT_X;
            r_y     <= ENT_Y;
            r_bump  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_bump <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd)
                            CMD_RIGHT, CMD_LEFT, CMD_UP, CMD_DOWN: begin
                                r_cmd   <= bus.cmd;
                                r_state <= ST_CHECK;
                            end
                            CMD_QUIT: begin
                                r_done  <= 1'b1;
                                r_state <= ST_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CHECK: begin
                    if (w_blocked) begin
                        r_bump  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_x     <= w_tx;
                        r_y     <= w_ty;
                        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                        r_state <= ST_REVEAL;
                    end
                end
                ST_REVEAL: begin
                    if (w_sc_last) begin
                        if (w_pos == EXIT_A) begin
                            r_done  <= 1'b1;
                            r_state <= ST_HALT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_done <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_explorer.sv
// Self-checking bench for grid_explorer against a whole-map behavioural model.
module tb_grid_explorer;
    localparam int W    = 10;
    localparam int H    = 10;
    localparam int R    = 2;
    localparam int ENT  = 50;
    localparam int EXT  = 59;
    localparam int N    = W * H;
    localparam int IW   = 7;
    localparam int SCAN = (2*R+1) * (2*R+1);

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] rd_addr;
    logic [2:0]    rd_data;
    logic [IW-1:0] pos;
    logic          bump;
    logic          done;
    logic [15:0]   move_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int m_map [N];
    bit m_seen [N];
    int m_x, m_y, m_count;
    bit m_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    grid_explorer_if #(.IDX_W(IW)) bus ();

    grid_explorer #(
        .MAP_W(W), .MAP_H(H), .REVEAL_R(R),
        .ENTRANCE_IDX(ENT), .EXIT_IDX(EXT), .IDX_W(IW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_pos       (pos),
        .o_bump      (bump),
        .o_done      (done),
        .o_move_count(move_count)
    );

    // ---------------- reference model ----------------
    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int m_pos();
        return m_y * W + m_x;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_map[i]  = (i == ENT) ? 2 : (i == EXT) ? 3 : 4;
            m_seen[i] = 1'b0;
        end
        m_x = ENT % W; m_y = ENT / W; m_count = 0; m_done = 1'b0;
    endfunction

    function automatic void m_reveal();
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                if (iabs(xx - m_x) + iabs(yy - m_y) <= R) m_seen[yy*W + xx] = 1'b1;
    endfunction

    function automatic void m_write(input int a, input int d);
        if (a < N && a != ENT && a != EXT && !(d == 5 && a == m_pos())) m_map[a] = d;
    endfunction

    function automatic int m_rd(input int a);
        if (a == m_pos()) return 1;
        if (a >= N)       return 0;
        if (!m_seen[a])   return 0;
        return m_map[a];
    endfunction

    // kind: 0 nop, 1 bump, 2 move, 3 quit, 4 move onto exit
    function automatic int m_step(input int c);
        int nx, ny;
        nx = m_x; ny = m_y;
        if (c == 5) begin m_done = 1'b1; return 3; end
        if (c < 1 || c > 4) return 0;
        case (c)
            1: nx = m_x + 1;
            2: nx = m_x - 1;
            3: ny = m_y - 1;
            default: ny = m_y + 1;
        endcase
        if (nx < 0 || nx >= W || ny < 0 || ny >= H) return 1;
        if (m_map[ny*W + nx] == 5) return 1;
        m_x = nx; m_y = ny;
        if (m_count < 65535) m_count++;
        m_reveal();
        if (m_pos() == EXT) begin m_done = 1'b1; return 4; end
        return 2;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input bit wait_reveal);
        bus.cmd_valid = 1'b0; bus.cmd = 3'd0; bus.map_we = 1'b0;
        bus.map_waddr = '0; bus.map_wdata = 3'd0; rd_addr = '0;
        reset = 1'b1;
        tick();
        m_reset();
        n_checks++;
        if (int'(pos) !== ENT || done !== 1'b0 || move_count !== 16'd0 || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: got pos=%0d done=%0d cnt=%0d rdy=%0d expected pos=%0d done=0 cnt=0 rdy=0",
                     pos, done, move_count, bus.cmd_ready, ENT);
        end
        tick();
        reset = 1'b0;
        if (wait_reveal) begin
            repeat (SCAN + 1) tick();
            m_reveal();
        end
    endtask

    task automatic do_write(input int a, input int d);
        bus.map_we = 1'b1; bus.map_waddr = IW'(a); bus.map_wdata = 3'(d);
        tick();
        bus.map_we = 1'b0;
        m_write(a, d);
    endtask

    task automatic check_map(input string tag);
        for (int a = 0; a < (1 << IW); a++) begin
            rd_addr = IW'(a);
            #1;
            n_checks++;
            if (int'(rd_data) !== m_rd(a)) begin
                n_fail++;
                $display("FAIL map_%s[%0d]: got %0d expected %0d", tag, a, rd_data, m_rd(a));
            end
        end
    endtask

    task automatic do_cmd(input int c);
        int n, kind, exp_lat, lat, bumps;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: got %0d expected 1", bus.cmd_ready);
            return;
        end
        bus.cmd_valid = 1'b1; bus.cmd = 3'(c);
        tick();
        bus.cmd_valid = 1'b0;
        kind    = m_step(c);
        exp_lat = (kind == 2 || kind == 4) ? SCAN + 1 : (kind == 1) ? 1 : 0;
        lat     = 0;
        bumps   = int'(bump);
        while (!(bus.cmd_ready === 1'b1 || done === 1'b1) && lat < 100) begin
            tick(); lat++; bumps += int'(bump);
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL latency cmd%0d: got %0d expected %0d", c, lat, exp_lat);
        end
        n_checks++;
        if (bumps !== ((kind == 1) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL bump_count cmd%0d: got %0d expected %0d", c, bumps, (kind == 1) ? 1 : 0);
        end
        n_checks++;
        if (int'(pos) !== m_pos() || int'(move_count) !== m_count || done !== m_done) begin
            n_fail++;
            $display("FAIL state cmd%0d: got pos=%0d cnt=%0d done=%0d expected pos=%0d cnt=%0d done=%0d",
                     c, pos, move_count, done, m_pos(), m_count, m_done);
        end
        n_checks++;
        if (bus.cmd_ready !== !m_done) begin
            n_fail++;
            $display("FAIL ready_after cmd%0d: got %0d expected %0d", c, bus.cmd_ready, !m_done);
        end
        tick();
        n_checks++;
        if (bump !== 1'b0) begin
            n_fail++;
            $display("FAIL bump_pulse cmd%0d: got %0d expected 0", c, bump);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int seen_cnt;
        do_reset(1'b0);
        repeat (SCAN - 1) tick();
        n_checks++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_during_reveal: got %0d expected 0", bus.cmd_ready);
        end
        repeat (2) tick();
        m_reveal();
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || int'(pos) !== 50) begin
            n_fail++;
            $display("FAIL after_reveal: got rdy=%0d pos=%0d expected rdy=1 pos=50", bus.cmd_ready, pos);
        end
        rd_addr = 7'd52; #1;
        n_checks++;
        if (rd_data !== 3'd4) begin n_fail++; $display("FAIL rd52: got %0d expected 4", rd_data); end
        rd_addr = 7'd50; #1;
        n_checks++;
        if (rd_data !== 3'd1) begin n_fail++; $display("FAIL rd50: got %0d expected 1", rd_data); end
        rd_addr = 7'd53; #1;
        n_checks++;
        if (rd_data !== 3'd0) begin n_fail++; $display("FAIL rd53: got %0d expected 0", rd_data); end
        rd_addr = 7'd0; #1;
        n_checks++;
        if (rd_data !== 3'd0) begin n_fail++; $display("FAIL rd0: got %0d expected 0", rd_data); end
        seen_cnt = 0;
        for (int a = 0; a < N; a++) begin
            rd_addr = IW'(a); #1;
            if (rd_data !== 3'd0) seen_cnt++;
        end
        n_checks++;
        if (seen_cnt !== 9) begin n_fail++; $display("FAIL reveal_count: got %0d expected 9", seen_cnt); end
        check_map("reset");
    endtask

    task automatic test_bump_edge();
        do_cmd(2);
        n_checks++;
        if (int'(pos) !== 50 || move_count !== 16'd0) begin
            n_fail++;
            $display("FAIL bump_left: got pos=%0d cnt=%0d expected pos=50 cnt=0", pos, move_count);
        end
        do_cmd(0);
        do_cmd(7);
        check_map("bump");
    endtask

    task automatic test_wall();
        do_write(51, 5);
        rd_addr = 7'd51; #1;
        n_checks++;
        if (rd_data !== 3'd5) begin n_fail++; $display("FAIL rd51_wall: got %0d expected 5", rd_data); end
        do_cmd(1);
        do_cmd(3);
        n_checks++;
        if (int'(pos) !== 40 || move_count !== 16'd1) begin
            n_fail++;
            $display("FAIL move_up: got pos=%0d cnt=%0d expected pos=40 cnt=1", pos, move_count);
        end
        rd_addr = 7'd20; #1;
        n_checks++;
        if (rd_data !== 3'd4) begin n_fail++; $display("FAIL rd20: got %0d expected 4", rd_data); end
        do_write(40, 5);
        do_write(50, 5);
        do_write(59, 4);
        do_write(110, 5);
        do_cmd(1);
        rd_addr = 7'd40; #1;
        n_checks++;
        if (rd_data !== 3'd4) begin n_fail++; $display("FAIL wall_on_pos: got %0d expected 4", rd_data); end
        check_map("wall");
    endtask

    task automatic test_walk_to_exit();
        int hs [$];
        int k, kind;
        do_reset(1'b1);
        bus.cmd = 3'd1; bus.cmd_valid = 1'b1;
        k = 0;
        while (done !== 1'b1 && k < 400) begin
            if (bus.cmd_ready === 1'b1) begin
                hs.push_back(cyc);
                kind = m_step(1);
            end
            tick(); k++;
        end
        repeat (10) begin
            n_checks++;
            if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready: got %0d expected 0", bus.cmd_ready); end
            tick();
        end
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (hs.size() !== 9) begin n_fail++; $display("FAIL walk_handshakes: got %0d expected 9", hs.size()); end
        for (int i = 1; i < hs.size(); i++) begin
            n_checks++;
            if (hs[i] - hs[i-1] !== SCAN + 2) begin
                n_fail++;
                $display("FAIL walk_spacing[%0d]: got %0d expected %0d", i, hs[i] - hs[i-1], SCAN + 2);
            end
        end
        n_checks++;
        if (int'(pos) !== 59 || done !== 1'b1 || move_count !== 16'd9 || m_done !== 1'b1) begin
            n_fail++;
            $display("FAIL walk_end: got pos=%0d done=%0d cnt=%0d expected pos=59 done=1 cnt=9", pos, done, move_count);
        end
        check_map("walk");
    endtask

    task automatic test_reset_mid_reveal();
        int n;
        do_reset(1'b1);
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
        bus.cmd_valid = 1'b1; bus.cmd = 3'd3;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        m_reset();
        n_checks++;
        if (int'(pos) !== 50 || move_count !== 16'd0 || done !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_vals: got pos=%0d cnt=%0d done=%0d rdy=%0d expected 50/0/0/0",
                     pos, move_count, done, bus.cmd_ready);
        end
        tick();
        reset = 1'b0;
        repeat (3) tick();
        rd_addr = 7'd40; #1;
        n_checks++;
        if (int'(rd_data) !== m_rd(40)) begin n_fail++; $display("FAIL rd40_fogged: got %0d expected %0d", rd_data, m_rd(40)); end
        repeat (SCAN - 2) tick();
        m_reveal();
        rd_addr = 7'd40; #1;
        n_checks++;
        if (rd_data !== 3'd4 || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd40_revealed: got rd=%0d rdy=%0d expected rd=4 rdy=1", rd_data, bus.cmd_ready);
        end
        check_map("abort");
    endtask

    task automatic test_quit();
        do_reset(1'b1);
        do_cmd(5);
        bus.cmd_valid = 1'b1; bus.cmd = 3'd4;
        repeat (10) tick();
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (int'(pos) !== 50 || done !== 1'b1 || bus.cmd_ready !== 1'b0 || move_count !== 16'd0) begin
            n_fail++;
            $display("FAIL quit_halt: got pos=%0d done=%0d rdy=%0d cnt=%0d expected 50/1/0/0",
                     pos, done, bus.cmd_ready, move_count);
        end
    endtask

    task automatic test_random();
        int r, c, d;
        do_reset(1'b1);
        for (int it = 0; it < 80 && !m_done; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 35) begin
                d = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) :
                    ($urandom_range(0, 1) == 0) ? 5 : 4;
                do_write(int'($urandom_range(0, (1 << IW) - 1)), d);
            end else begin
                r = int'($urandom_range(0, 99));
                c = (r < 2) ? 5 : (r < 8) ? int'($urandom_range(6, 7)) :
                    (r < 12) ? 0 : int'($urandom_range(1, 4));
                do_cmd(c);
                check_map("rand");
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd = 3'd0; bus.map_we = 1'b0;
        bus.map_waddr = '0; bus.map_wdata = 3'd0; rd_addr = '0;
        test_reset();
        test_bump_edge();
        test_wall();
        test_walk_to_exit();
        test_reset_mid_reveal();
        test_quit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
